// File: rtl/uart_pkg.sv
// ============================================================================
// Package     : uart_pkg
// Description : Shared types and constants for the UART transmit path.
//               Optional feature macro: UART_TX_PARITY_EN (adds the PARITY
//               state for even-parity framing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_t;
`endif

  // Even parity bit: makes the total number of ones in data+parity even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_core_if.sv
// ============================================================================
// Interface   : uart_tx_core_if
// Description : Store-path / status / line bundle of the UART transmitter.
//               master = LSU/status side, slave = uart_tx_core.
//               Optional feature macro: UART_TX_PARITY_EN (no effect here).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_core_if #(
  parameter int DIV_W = 16
) ();

  logic [7:0]       data_in;
  logic             wr_en;
  logic [DIV_W-1:0] baud_div;
  logic             txff;
  logic             txfe;
  logic             tx_busy;
  logic             tx;

  modport master (
    output data_in, wr_en, baud_div,
    input  txff, txfe, tx_busy, tx
  );

  modport slave (
    input  data_in, wr_en, baud_div,
    output txff, txfe, tx_busy, tx
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding the UART serializer. Push from the store
//               path (dropped silently when full), pop from the TX FSM.
//               Optional feature macro: UART_TX_PARITY_EN (no effect here).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       wr_en_i,
  input  wire logic [7:0] data_i,
  input  wire logic       pop_i,
  output logic      [7:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          w_push;
  logic          w_pop;

  // Flags are decoded from the occupancy count, before the edge.
  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign w_push  = wr_en_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_core.sv
// ============================================================================
// Module      : uart_tx_core
// Description : UART transmitter: byte FIFO plus baud-timed 8N1 serializer.
//               Optional feature macro: UART_TX_PARITY_EN - inserts an
//               even-parity bit between the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  uart_tx_core_if.slave bus
);

  localparam logic [2:0] C_LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [DIV_W-1:0]          div_q;
  logic [DIV_W-1:0]          baud_cnt_q;
  logic [2:0]                bit_cnt_q;
  logic                      tx_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_bit_end;
  logic       w_pop;

  assign w_bit_end = (baud_cnt_q == '0);
  // The FSM pops when leaving IDLE or at the end of STOP with data waiting.
  assign w_pop     = !w_empty && ((state_q == IDLE) || ((state_q == STOP) && w_bit_end));

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (bus.wr_en),
    .data_i  (bus.data_in),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.txff    = w_full;
  assign bus.txfe    = w_empty;
  assign bus.tx_busy = (state_q != IDLE);
  assign bus.tx      = tx_q;

  // Serializer FSM: baud counter, bit counter, shift register and tx line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (!w_empty) begin
            shift_q    <= w_head;
            div_q      <= bus.baud_div;
            baud_cnt_q <= bus.baud_div;
            tx_q       <= 1'b0;
            state_q    <= START;
`ifdef UART_TX_PARITY_EN
            parity_q   <= even_parity(w_head);
`endif
          end
        end

        START: begin
          if (w_bit_end) begin
            tx_q       <= shift_q[0];
            shift_q    <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_q  <= '0;
            baud_cnt_q <= div_q;
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end

        DATA: begin
          if (w_bit_end) begin
            baud_cnt_q <= div_q;
            if (bit_cnt_q == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            tx_q       <= UART_IDLE_LEVEL;
            baud_cnt_q <= div_q;
            state_q    <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end
`endif

        STOP: begin
          if (w_bit_end) begin
            if (!w_empty) begin
              // Chain straight into the next frame with no idle gap.
              shift_q    <= w_head;
              div_q      <= bus.baud_div;
              baud_cnt_q <= bus.baud_div;
              tx_q       <= 1'b0;
              state_q    <= START;
`ifdef UART_TX_PARITY_EN
              parity_q   <= even_parity(w_head);
`endif
            end else begin
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end

        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// ============================================================================
// Module      : tb_uart_tx_core
// Description : Self-checking directed testbench for uart_tx_core.
//               Optional feature macro: UART_TX_PARITY_EN (parity frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_tx_core_if #(.DIV_W(16)) bus ();

  uart_tx_core #(.DEPTH(8), .DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected line level for bit j of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.data_in = 8'h00;
    bus.baud_div = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.tx, bus.txfe, bus.txff, bus.tx_busy} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: tx/txfe/txff/busy got %b expected 1100", i,
                 {bus.tx, bus.txfe, bus.txff, bus.tx_busy});
      end
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] exp_a5;
`ifdef UART_TX_PARITY_EN
    exp_a5 = 11'b10101001010;
`else
    exp_a5 = 11'b01101001010;
`endif
    bus.baud_div = 16'd3;
    bus.data_in = 8'hA5;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.txfe !== 1'b0 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_push: txfe/tx got %b%b expected 01", bus.txfe, bus.tx);
    end
    @(negedge clk);
    for (int i = 0; i < NB * 4; i++) begin
      n_checks++;
      if (bus.tx !== exp_a5[i/4] || bus.tx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_a5 sample %0d: tx/busy got %b%b expected %b1", i,
                 bus.tx, bus.tx_busy, exp_a5[i/4]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({bus.tx, bus.txfe, bus.tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL frame_a5_end: tx/txfe/busy got %b expected 110",
               {bus.tx, bus.txfe, bus.tx_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [9];
    for (int k = 0; k < 8; k++) bytes[k] = 8'h20 + 8'(k);
    bytes[8] = 8'h5A;
    // Long first frame keeps the serializer busy while the FIFO fills.
    bus.baud_div = 16'd20;
    bus.data_in = 8'h11;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.tx !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_start: tx got %b expected 0", bus.tx);
    end
    for (int k = 0; k < 8; k++) begin
      bus.wr_en = 1'b1;
      bus.data_in = bytes[k];
      @(negedge clk);
    end
    n_checks++;
    if (bus.txff !== 1'b1 || bus.txfe !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: txff/txfe got %b%b expected 10", bus.txff, bus.txfe);
    end
    bus.data_in = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.txff !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drop: txff got %b expected 1", bus.txff);
    end
    // Mid-frame divisor change must not shorten the current frame.
    bus.baud_div = 16'd0;
    repeat (NB * 21 - 10) @(negedge clk);
    n_checks++;
    if (bus.tx_busy !== 1'b1 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL frame0_stop: busy/tx got %b%b expected 11", bus.tx_busy, bus.tx);
    end
    bus.wr_en = 1'b1;
    bus.data_in = 8'hEE;
    @(negedge clk);
    n_checks++;
    if (bus.txff !== 1'b0 || bus.txfe !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_same_cycle: txff/txfe got %b%b expected 00", bus.txff, bus.txfe);
    end
    bus.data_in = 8'h5A;
    for (int i = 0; i < 9 * NB; i++) begin
      if (i == 1) begin
        bus.wr_en = 1'b0;
        n_checks++;
        if (bus.txff !== 1'b1) begin
          n_fail++;
          $display("FAIL refill_after_pop: txff got %b expected 1", bus.txff);
        end
      end
      n_checks++;
      if (bus.tx !== frame_bit(bytes[i/NB], i % NB)) begin
        n_fail++;
        $display("FAIL b2b_frames sample %0d: tx got %b expected %b", i, bus.tx,
                 frame_bit(bytes[i/NB], i % NB));
      end
      @(negedge clk);
    end
    n_checks++;
    if ({bus.tx, bus.txfe, bus.tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_end: tx/txfe/busy got %b expected 110",
               {bus.tx, bus.txfe, bus.tx_busy});
    end
  endtask

  task automatic test_reset_midframe();
    bus.baud_div = 16'd3;
    bus.wr_en = 1'b1;
    bus.data_in = 8'hFF;
    @(negedge clk);
    bus.data_in = 8'hAA;
    @(negedge clk);
    bus.data_in = 8'hBB;
    @(negedge clk);
    bus.data_in = 8'hCC;
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (19) @(negedge clk);
    n_checks++;
    if (bus.tx_busy !== 1'b1 || bus.txfe !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_busy: busy/txfe got %b%b expected 10", bus.tx_busy, bus.txfe);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.tx, bus.txfe, bus.txff, bus.tx_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL midframe_reset: tx/txfe/txff/busy got %b expected 1100",
               {bus.tx, bus.txfe, bus.txff, bus.tx_busy});
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.tx !== 1'b1 || bus.txfe !== 1'b1 || bus.tx_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet cyc %0d: tx/txfe/busy got %b%b%b expected 110", i,
                 bus.tx, bus.txfe, bus.tx_busy);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] exp07;
    logic [10:0] exp03;
    exp07 = 11'b11000001110;
    exp03 = 11'b10000000110;
    bus.baud_div = 16'd1;
    bus.wr_en = 1'b1;
    bus.data_in = 8'h07;
    @(negedge clk);
    bus.data_in = 8'h03;
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 44; i++) begin
      n_checks++;
      if (i < 22 && bus.tx !== exp07[i/2]) begin
        n_fail++;
        $display("FAIL parity_07 sample %0d: tx got %b expected %b", i, bus.tx, exp07[i/2]);
      end else if (i >= 22 && bus.tx !== exp03[(i-22)/2]) begin
        n_fail++;
        $display("FAIL parity_03 sample %0d: tx got %b expected %b", i, bus.tx,
                 exp03[(i-22)/2]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_end: tx/busy got %b%b expected 10", bus.tx, bus.tx_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
